// File: rtl/uart_rx_buffer_reg_if.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer_reg_if
//
// Groups the RX FIFO read port and the peripheral register-bus signals of the
// UART receive buffer.
//
// Signal summary:
//   rx_fifo_rd           buffer -> FIFO   pop strobe, one cycle wide
//   rx_fifo_rd_data[31:0] FIFO -> buffer  pop data, valid the cycle after rx_fifo_rd
//   rx_fifo_rd_num[7:0]  FIFO -> buffer   FIFO occupancy
//   slv_reg_rden         bus -> buffer    read strobe for the RX data register
//   slv_reg_clr          bus -> buffer    write-1-to-clear strobe for underflow
//   peripheral_data_out  buffer -> bus    registered read data
//   rfi[31:0]            buffer -> bus    RX status word
//
// Modports:
//   master : environment side (FIFO + bus), drives the strobes and FIFO data
//   slave  : the buffer itself
// -----------------------------------------------------------------------------
interface uart_rx_buffer_reg_if;
    logic        rx_fifo_rd;
    logic [31:0] rx_fifo_rd_data;
    logic [7:0]  rx_fifo_rd_num;
    logic        slv_reg_rden;
    logic        slv_reg_clr;
    logic [31:0] peripheral_data_out;
    logic [31:0] rfi;

    modport master (
        input  rx_fifo_rd,
        input  peripheral_data_out,
        input  rfi,
        output rx_fifo_rd_data,
        output rx_fifo_rd_num,
        output slv_reg_rden,
        output slv_reg_clr
    );

    modport slave (
        output rx_fifo_rd,
        output peripheral_data_out,
        output rfi,
        input  rx_fifo_rd_data,
        input  rx_fifo_rd_num,
        input  slv_reg_rden,
        input  slv_reg_clr
    );
endinterface

// File: rtl/uart_rx_buffer_reg.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer_reg
//
// Bus-side read buffer for the UART receive path. One word is prefetched from
// the RX FIFO into a holding register so it is ready when the bus reads the RX
// data register. A read of an empty holding register returns zero and sets a
// sticky underflow flag. A status word (prog-full, underflow, hold valid,
// readable word count) is published for software polling.
//
// Ports:
//   clk_125          single clock
//   rst_125          synchronous reset, active-high
//   bus              uart_rx_buffer_reg_if.slave (FIFO read port + register bus)
//   fsm_state[1:0]   debug view of the holding FSM: 0 EMPTY, 1 FETCH, 2 FULL
//   hold_data[31:0]  debug view of the holding register
//
// Strobe semantics (no valid/ready backpressure on either side):
//   rx_fifo_rd is a one-cycle pop request, issued only while rx_fifo_rd_num is
//   non-zero; the FIFO returns the word on rx_fifo_rd_data exactly one cycle
//   later. slv_reg_rden is a one-cycle read request that is always accepted;
//   peripheral_data_out carries the result from the next cycle until the next
//   read. slv_reg_clr is a one-cycle clear request for the underflow flag.
// -----------------------------------------------------------------------------
module uart_rx_buffer_reg #(
    parameter int unsigned RX_PROG_FULL_TH = 253
) (
    input  logic                  clk_125,
    input  logic                  rst_125,
    uart_rx_buffer_reg_if.slave   bus,
    output logic [1:0]            fsm_state,
    output logic [31:0]           hold_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Nine bits so a threshold of 256 (never prog-full) is still representable.
    localparam logic [8:0] PROG_FULL_TH = 9'(RX_PROG_FULL_TH);

    state_t      state_q;
    state_t      state_d;
    logic        rd_q;
    logic        rd_d;
    logic [31:0] hold_q;
    logic        hold_load;
    logic [31:0] pdo_q;
    logic [31:0] pdo_next;
    logic        pdo_load;
    logic        underflow_q;
    logic        underflow_set;
    logic        fifo_has_data;
    logic        prog_full;
    logic [8:0]  rfcn;

    assign fifo_has_data = (bus.rx_fifo_rd_num != 8'd0);

    // Next-state and datapath controls.
    always_comb begin
        state_d       = state_q;
        rd_d          = 1'b0;
        hold_load     = 1'b0;
        pdo_load      = 1'b0;
        pdo_next      = 32'h0000_0000;
        underflow_set = 1'b0;

        case (state_q)
            EMPTY: begin
                if (fifo_has_data) begin
                    rd_d    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // While the pop strobe is still high the FIFO data is not yet
                // valid; it arrives the cycle after, and is captured then.
                if (!rd_q) begin
                    hold_load = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (bus.slv_reg_rden) begin
                    pdo_load = 1'b1;
                    pdo_next = hold_q;
                    if (fifo_has_data) begin
                        rd_d    = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A read with nothing held returns zero; an in-flight fetch is left alone.
        if (bus.slv_reg_rden && (state_q != FULL)) begin
            pdo_load      = 1'b1;
            pdo_next      = 32'h0000_0000;
            underflow_set = 1'b1;
        end
    end

    always_ff @(posedge clk_125) begin
        if (rst_125) begin
            state_q     <= EMPTY;
            rd_q        <= 1'b0;
            hold_q      <= 32'h0000_0000;
            pdo_q       <= 32'h0000_0000;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            if (hold_load) begin
                hold_q <= bus.rx_fifo_rd_data;
            end
            if (pdo_load) begin
                pdo_q <= pdo_next;
            end
            // Set has priority over a simultaneous clear.
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (bus.slv_reg_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Status word. rfcn counts words software can still read: those in the
    // FIFO plus the one held or being fetched; 255 + 1 = 256 needs nine bits.
    assign prog_full = ({1'b0, bus.rx_fifo_rd_num} >= PROG_FULL_TH);
    assign rfcn      = {1'b0, bus.rx_fifo_rd_num} + {8'd0, (state_q != EMPTY)};

    assign bus.rfi                 = {prog_full, underflow_q, (state_q == FULL), 20'd0, rfcn};
    assign bus.rx_fifo_rd          = rd_q;
    assign bus.peripheral_data_out = pdo_q;

    assign fsm_state = state_q;
    assign hold_data = hold_q;

endmodule
